mac_lane_array: RTL and testbench

- Parametrised multi-lane multiply-and-accumulate engine; next generation of the single-lane digital MAC.
- LANES independent signed MACs share a control FSM and accumulate a run-time-programmed number of beats, for example one kernel window.
- Multiply is pipelined. The result is saturated to OUT_W and presented on a valid/ready output handshake.
- Sits between the activation/weight fetch logic and the post-processing (ReLU/pooling) stage of the CNN datapath.

---
 rtl/mac_pkg.sv | 47 ++++
 rtl/mac_lane.sv | 68 ++++++
 rtl/mac_lane_array.sv | 114 +++++++++++
 tb/tb_mac_lane_array.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the multi-lane MAC engine.
// State encoding, accumulator sizing and signed saturation.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUT
  } state_t;

  typedef struct packed {
    logic [63:0] value;
    logic        flag;
  } sat_t;

  function automatic int acc_width(
    input int dw,
    input int ww,
    input int max_len
  );
    return dw + ww + $clog2(max_len);
  endfunction

  // Clip a sign-extended accumulator into a w-bit signed range.
  function automatic sat_t saturate(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.flag = 1'b1;
    if (v > hi) begin
      r.value = hi;
    end else if (v < lo) begin
      r.value = lo;
    end else begin
      r.value = v;
      r.flag  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed MAC lane: product register, accumulator and
// saturated result register, strobed by the shared FSM.
module mac_lane
  import mac_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int OUT_W    = 16,
  parameter int ACC_W    = 24
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      mul_en,
  input  logic                      acc_en,
  input  logic                      load,
  input  logic signed [DATA_W-1:0]  a,
  input  logic signed [WEIGHT_W-1:0] b,
  output logic signed [OUT_W-1:0]   sum,
  output logic                      sat
);

  localparam int P_W = DATA_W + WEIGHT_W;

  logic signed [P_W-1:0]   prod;
  logic                    prod_valid;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  sat_t                    clip;

  // The result register samples the post-add value so that the
  // draining edge can publish the final sum directly.
  always_comb begin
    acc_next = acc;
    if (clear) begin
      acc_next = '0;
    end else if (acc_en && prod_valid) begin
      acc_next = acc + ACC_W'(prod);
    end
    clip = saturate(64'(acc_next), OUT_W);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
      sum        <= '0;
      sat        <= 1'b0;
    end else begin
      if (clear) begin
        prod       <= '0;
        prod_valid <= 1'b0;
      end else begin
        prod_valid <= mul_en;
        if (mul_en) begin
          prod <= P_W'(a) * P_W'(b);
        end
      end
      acc <= acc_next;
      if (load) begin
        sum <= clip.value[OUT_W-1:0];
        sat <= clip.flag;
      end
    end
  end

endmodule

// File: rtl/mac_lane_array.sv
// LANES signed MACs under one control FSM accumulating a
// programmed number of beats, with a saturated valid/ready result.
module mac_lane_array
  import mac_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int OUT_W    = 16,
  parameter int MAX_LEN  = 256,
  parameter int LEN_W    = 9
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [LEN_W-1:0]            length,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_W-1:0]     data_in,
  input  logic [LANES*WEIGHT_W-1:0]   weight_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*OUT_W-1:0]      data_out,
  output logic [LANES-1:0]            sat_flag,
  output logic                        busy
);

  localparam int ACC_W = acc_width(DATA_W, WEIGHT_W, MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t           state;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_c;
  logic             accept;
  logic             clear;
  logic             acc_en;
  logic             load;

  always_comb begin
    len_c  = (length > MAX_L) ? MAX_L : length;
    accept = in_valid && in_ready;
    clear  = (state == IDLE) && start;
    acc_en = (state == ACCUM) || (state == DRAIN);
    load   = (state == DRAIN) || (clear && (len_c == '0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            count <= len_c;
            busy  <= 1'b1;
            if (len_c != '0) begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end else begin
              state     <= OUT;
              out_valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            count <= count - LEN_W'(1);
            if (count == LEN_W'(1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state     <= OUT;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .DATA_W  (DATA_W),
      .WEIGHT_W(WEIGHT_W),
      .OUT_W   (OUT_W),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .mul_en(accept),
      .acc_en(acc_en),
      .load  (load),
      .a     (data_in[i*DATA_W +: DATA_W]),
      .b     (weight_in[i*WEIGHT_W +: WEIGHT_W]),
      .sum   (data_out[i*OUT_W +: OUT_W]),
      .sat   (sat_flag[i])
    );
  end

endmodule

// File: tb/tb_mac_lane_array.sv
// Directed bench for mac_lane_array with hand-computed results.
// Inputs change and outputs are sampled on the falling edge.
module tb_mac_lane_array;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  length;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [31:0] weight_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;
  logic [3:0]  sat_flag;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] held;

  mac_lane_array dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .length   (length),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .weight_in(weight_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .sat_flag (sat_flag),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(int v0, int v1, int v2, int v3);
    return {v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
  endfunction

  task automatic go(int n);
    start  = 1'b1;
    length = 9'(n);
    tick();
    start  = 1'b0;
  endtask

  task automatic beat(logic [31:0] d, logic [31:0] w);
    in_valid  = 1'b1;
    data_in   = d;
    weight_in = w;
    tick();
    in_valid  = 1'b0;
  endtask

  // Called right after the last beat's accepting edge.
  task automatic finish(string tag, logic [63:0] d, logic [3:0] s);
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, data_out, d);
    chk({tag, "_sat"}, 64'(sat_flag), 64'(s));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_done"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    length    = '0;
    in_valid  = 1'b0;
    data_in   = '0;
    weight_in = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_sat", 64'(sat_flag), 64'd0);

    // 2*3 - 4*5 + 7*-1 = -21 on lane 0
    go(3);
    chk("basic_ready", 64'(in_ready), 64'd1);
    chk("basic_busy", 64'(busy), 64'd1);
    beat(pk(2, 0, 0, 0), pk(3, 0, 0, 0));
    beat(pk(-4, 0, 0, 0), pk(5, 0, 0, 0));
    beat(pk(7, 0, 0, 0), pk(-1, 0, 0, 0));
    finish("basic", 64'h0000_0000_0000_FFEB, 4'h0);
    chk("basic_hold", data_out, 64'h0000_0000_0000_FFEB);
    chk("basic_idle", 64'(busy), 64'd0);

    // bubbles: 5*6 + -3*4 = 18 on lane 1
    go(2);
    beat(pk(0, 5, 0, 0), pk(0, 6, 0, 0));
    data_in   = pk(9, 9, 9, 9);
    weight_in = pk(9, 9, 9, 9);
    tick();
    chk("bub_ready", 64'(in_ready), 64'd1);
    tick();
    beat(pk(0, -3, 0, 0), pk(0, 4, 0, 0));
    chk("bub_lat1", 64'(out_valid), 64'd0);
    in_valid  = 1'b1;
    data_in   = pk(50, 50, 50, 50);
    weight_in = pk(50, 50, 50, 50);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", data_out, 64'h0000_0000_0012_0000);
      chk("bp_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_done", 64'(out_valid), 64'd0);
    chk("bp_hold", data_out, 64'h0000_0000_0012_0000);

    // 4 x 127*127 = 64516 clips positive on every lane
    go(4);
    repeat (4) beat(pk(127, 127, 127, 127), pk(127, 127, 127, 127));
    finish("sat_pos", 64'h7FFF_7FFF_7FFF_7FFF, 4'hF);

    // 3 x -128*127 = -48768 clips negative on lane 2
    go(3);
    repeat (3) beat(pk(0, 0, -128, 0), pk(0, 0, 127, 0));
    finish("sat_neg", 64'h0000_8000_0000_0000, 4'h4);

    // 2 x -128*-128 = 32768 clips by one on lane 3
    go(2);
    repeat (2) beat(pk(0, 0, 0, -128), pk(0, 0, 0, -128));
    finish("sat_edge", 64'h7FFF_0000_0000_0000, 4'h8);

    // zero-length run
    go(0);
    chk("zero_valid", 64'(out_valid), 64'd1);
    chk("zero_data", data_out, 64'd0);
    chk("zero_sat", 64'(sat_flag), 64'd0);
    chk("zero_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("zero_done", 64'(out_valid), 64'd0);

    // full length, 256 x 1*1
    go(256);
    repeat (256) beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    chk("len256_ready", 64'(in_ready), 64'd0);
    finish("len256", 64'h0100_0100_0100_0100, 4'h0);

    // 300 clamps to 256 beats
    go(300);
    repeat (256) beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    chk("clamp_ready", 64'(in_ready), 64'd0);
    finish("clamp", 64'h0100_0100_0100_0100, 4'h0);

    // reset after 2 of 5 beats
    go(5);
    beat(pk(4, 4, 4, 4), pk(4, 4, 4, 4));
    beat(pk(4, 4, 4, 4), pk(4, 4, 4, 4));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_data", data_out, 64'd0);
    chk("abort_sat", 64'(sat_flag), 64'd0);
    tick();
    chk("abort_quiet", 64'(out_valid), 64'd0);
    go(1);
    beat(pk(3, 0, 0, 0), pk(3, 0, 0, 0));
    finish("after_rst", 64'h0000_0000_0000_0009, 4'h0);

    // start during ACCUM is ignored: 1 + 4 + 9 = 14
    go(3);
    start  = 1'b1;
    length = 9'd1;
    beat(pk(1, 0, 0, 0), pk(1, 0, 0, 0));
    start = 1'b0;
    beat(pk(2, 0, 0, 0), pk(2, 0, 0, 0));
    chk("mid_start_ready", 64'(in_ready), 64'd1);
    beat(pk(3, 0, 0, 0), pk(3, 0, 0, 0));
    finish("mid_start", 64'h0000_0000_0000_000E, 4'h0);

    // back-to-back: 100 then an independent 6 on lane 1
    go(1);
    beat(pk(0, 10, 0, 0), pk(0, 10, 0, 0));
    tick();
    chk("b2b_first", data_out, 64'h0000_0000_0064_0000);
    out_ready = 1'b1;
    start     = 1'b1;
    length    = 9'd1;
    tick();
    out_ready = 1'b0;
    chk("b2b_idle", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    chk("b2b_ready", 64'(in_ready), 64'd1);
    beat(pk(0, 2, 0, 0), pk(0, 3, 0, 0));
    finish("b2b", 64'h0000_0000_0006_0000, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule
